// File: rtl/memory_port_arbiter.sv
// Arbitrates the core's fetch and load/store ports onto one single-ported memory.
// Data has priority, fetch is protected by a starvation limit, and one access is in flight at a time.
module memory_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic                  fetch_ready,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  data_req,
    input  logic                  data_write,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    output logic                  data_ready,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_read_data,
    output logic                  mem_enable,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] WAIT    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;

    localparam logic [2:0] LATENCY_LOAD = 3'(MEM_LATENCY - 1);
    localparam logic [3:0] LIMIT        = 4'(STARVE_LIMIT);

    logic [1:0]            state;
    logic                  owner_data;
    logic                  owner_write;
    logic [2:0]            count;
    logic [3:0]            starve_count;
    logic [ADDR_WIDTH-1:0] last_address;
    logic [DATA_WIDTH-1:0] last_write_data;

    logic can_issue;
    logic grant_data;
    logic grant_fetch;
    logic issue;

    // Issue is blocked while reset is held so every output reads 0 during reset.
    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        can_issue   = reset && (state != WAIT);
        grant_data  = can_issue && data_req && !(fetch_req && (starve_count == LIMIT));
        grant_fetch = can_issue && fetch_req && !grant_data;
        issue       = grant_data || grant_fetch;
    end

    assign fetch_ready    = grant_fetch;
    assign data_ready     = grant_data;
    assign mem_enable     = issue;
    assign mem_write      = grant_data && data_write;
    assign mem_address    = grant_data  ? data_address :
                            grant_fetch ? fetch_address : last_address;
    assign mem_write_data = grant_data  ? data_write_data : last_write_data;

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            owner_data      <= 1'b0;
            owner_write     <= 1'b0;
            count           <= 3'd0;
            starve_count    <= 4'd0;
            last_address    <= '0;
            last_write_data <= '0;
            fetch_valid     <= 1'b0;
            data_valid      <= 1'b0;
            fetch_data      <= '0;
            data_read_data  <= '0;
        end else begin
            fetch_valid <= 1'b0;
            data_valid  <= 1'b0;

            if (issue) begin
                owner_data      <= grant_data;
                owner_write     <= mem_write;
                count           <= LATENCY_LOAD;
                last_address    <= mem_address;
                last_write_data <= mem_write_data;
            end

            if (grant_fetch) begin
                starve_count <= 4'd0;
            end else if (grant_data && fetch_req && (starve_count != LIMIT)) begin
                starve_count <= starve_count + 4'd1;
            end

            case (state)
                IDLE, RESPOND: state <= issue ? WAIT : IDLE;
                WAIT: begin
                    if (count != 3'd0) begin
                        count <= count - 3'd1;
                    end else begin
                        state <= RESPOND;
                        if (owner_data) begin
                            data_valid <= 1'b1;
                            // A store completes without touching the load data register.
                            if (!owner_write) begin
                                data_read_data <= mem_read_data;
                            end
                        end else begin
                            fetch_valid <= 1'b1;
                            fetch_data  <= mem_read_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: one instance at MEM_LATENCY=1 and one at MEM_LATENCY=3
// share the same stimulus; each scenario checks the instance it targets.
module tb_memory_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_address;
    logic        data_req;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic [31:0] mem_read_data;

    logic        fetch_ready, fetch_valid, data_ready, data_valid, mem_enable, mem_write;
    logic [31:0] fetch_data, data_read_data, mem_address, mem_write_data;

    logic        s3_fetch_ready, s3_fetch_valid, s3_data_ready, s3_data_valid, s3_mem_enable, s3_mem_write;
    logic [31:0] s3_fetch_data, s3_data_read_data, s3_mem_address, s3_mem_write_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_d;

    always #5 clock = ~clock;

    memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u1 (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_address(fetch_address),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .data_req(data_req), .data_write(data_write), .data_address(data_address),
        .data_write_data(data_write_data), .data_ready(data_ready), .data_valid(data_valid),
        .data_read_data(data_read_data),
        .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    memory_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u3 (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_address(fetch_address),
        .fetch_ready(s3_fetch_ready), .fetch_valid(s3_fetch_valid), .fetch_data(s3_fetch_data),
        .data_req(data_req), .data_write(data_write), .data_address(data_address),
        .data_write_data(data_write_data), .data_ready(s3_data_ready), .data_valid(s3_data_valid),
        .data_read_data(s3_data_read_data),
        .mem_enable(s3_mem_enable), .mem_write(s3_mem_write), .mem_address(s3_mem_address),
        .mem_write_data(s3_mem_write_data), .mem_read_data(mem_read_data)
    );

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_req       = 1'b0;
        fetch_address   = 32'h0;
        data_req        = 1'b0;
        data_write      = 1'b0;
        data_address    = 32'h0;
        data_write_data = 32'h0;
        mem_read_data   = 32'h0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        next_cycle();
        next_cycle();
        @(negedge clock);
        check_word("reset fetch_data", fetch_data, 32'h0);
        check_word("reset data_read_data", data_read_data, 32'h0);
        check_bit("reset fetch_valid", fetch_valid, 1'b0);
        check_bit("reset data_valid", data_valid, 1'b0);
        check_bit("reset mem_enable", mem_enable, 1'b0);
        check_bit("reset mem_write", mem_write, 1'b0);
        check_word("reset mem_address", mem_address, 32'h0);
        check_word("reset mem_write_data", mem_write_data, 32'h0);
        reset = 1'b1;

        // Single fetch, latency 1
        next_cycle();
        fetch_req = 1'b1; fetch_address = 32'h10;
        @(negedge clock);
        check_bit("fetch c0 fetch_ready", fetch_ready, 1'b1);
        check_bit("fetch c0 mem_enable", mem_enable, 1'b1);
        check_word("fetch c0 mem_address", mem_address, 32'h10);
        check_bit("fetch c0 mem_write", mem_write, 1'b0);
        next_cycle();
        fetch_req = 1'b0; mem_read_data = 32'hE3A00001;
        @(negedge clock);
        check_bit("fetch c1 fetch_valid", fetch_valid, 1'b0);
        check_bit("fetch c1 mem_enable", mem_enable, 1'b0);
        check_word("fetch c1 mem_address held", mem_address, 32'h10);
        next_cycle();
        mem_read_data = 32'hDEADBEEF;
        @(negedge clock);
        check_bit("fetch c2 fetch_valid", fetch_valid, 1'b1);
        check_word("fetch c2 fetch_data", fetch_data, 32'hE3A00001);
        next_cycle();
        @(negedge clock);
        check_bit("fetch c3 fetch_valid", fetch_valid, 1'b0);
        check_word("fetch c3 fetch_data held", fetch_data, 32'hE3A00001);

        // Simultaneous requests: data first
        apply_reset();
        fetch_req = 1'b1; fetch_address = 32'h0;
        data_req = 1'b1; data_address = 32'h64;
        @(negedge clock);
        check_bit("simul c0 data_ready", data_ready, 1'b1);
        check_bit("simul c0 fetch_ready", fetch_ready, 1'b0);
        check_word("simul c0 mem_address", mem_address, 32'h64);
        next_cycle();
        data_req = 1'b0; mem_read_data = 32'h11111111;
        @(negedge clock);
        check_bit("simul c1 fetch_ready", fetch_ready, 1'b0);
        check_bit("simul c1 mem_enable", mem_enable, 1'b0);
        next_cycle();
        mem_read_data = 32'h0;
        @(negedge clock);
        check_bit("simul c2 data_valid", data_valid, 1'b1);
        check_word("simul c2 data_read_data", data_read_data, 32'h11111111);
        check_bit("simul c2 fetch_ready", fetch_ready, 1'b1);
        check_word("simul c2 mem_address", mem_address, 32'h0);
        next_cycle();
        fetch_req = 1'b0; mem_read_data = 32'h22222222;
        @(negedge clock);
        check_bit("simul c3 fetch_valid", fetch_valid, 1'b0);
        check_bit("simul c3 data_valid", data_valid, 1'b0);
        next_cycle();
        mem_read_data = 32'h0;
        @(negedge clock);
        check_bit("simul c4 fetch_valid", fetch_valid, 1'b1);
        check_word("simul c4 fetch_data", fetch_data, 32'h22222222);
        check_bit("simul c4 data_valid", data_valid, 1'b0);

        // Starvation limit: both requests held, issues every other cycle
        apply_reset();
        fetch_req = 1'b1; fetch_address = 32'h40;
        data_req = 1'b1; data_address = 32'h80;
        mem_read_data = 32'hA5A5A5A5;
        for (int k = 0; k < 6; k++) begin
            exp_d = (k != 4);
            @(negedge clock);
            check_bit($sformatf("starve issue%0d data_ready", k), data_ready, exp_d);
            check_bit($sformatf("starve issue%0d fetch_ready", k), fetch_ready, !exp_d);
            next_cycle();
            @(negedge clock);
            check_bit($sformatf("starve wait%0d mem_enable", k), mem_enable, 1'b0);
            next_cycle();
        end
        fetch_req = 1'b0; data_req = 1'b0;
        next_cycle();

        // Store: strobe once, data_read_data untouched
        data_req = 1'b1; data_write = 1'b1; data_address = 32'h64; data_write_data = 32'h7;
        @(negedge clock);
        check_bit("store c0 data_ready", data_ready, 1'b1);
        check_bit("store c0 mem_write", mem_write, 1'b1);
        check_word("store c0 mem_address", mem_address, 32'h64);
        check_word("store c0 mem_write_data", mem_write_data, 32'h7);
        next_cycle();
        data_req = 1'b0; data_write = 1'b0; mem_read_data = 32'h55555555;
        @(negedge clock);
        check_bit("store c1 mem_write", mem_write, 1'b0);
        check_word("store c1 mem_write_data held", mem_write_data, 32'h7);
        next_cycle();
        @(negedge clock);
        check_bit("store c2 data_valid", data_valid, 1'b1);
        check_word("store c2 data_read_data", data_read_data, 32'hA5A5A5A5);
        next_cycle();
        @(negedge clock);
        check_bit("store c3 data_valid", data_valid, 1'b0);

        // Latency 3 on the second instance, with a held second request
        apply_reset();
        data_req = 1'b1; data_address = 32'h64; mem_read_data = 32'hBAD0BAD0;
        @(negedge clock);
        check_bit("lat3 c0 data_ready", s3_data_ready, 1'b1);
        check_bit("lat3 c0 mem_enable", s3_mem_enable, 1'b1);
        for (int c = 1; c < 4; c++) begin
            next_cycle();
            mem_read_data = (c == 3) ? 32'hC0FFEE03 : 32'hBAD0BAD0;
            @(negedge clock);
            check_bit($sformatf("lat3 c%0d data_ready", c), s3_data_ready, 1'b0);
            check_bit($sformatf("lat3 c%0d data_valid", c), s3_data_valid, 1'b0);
        end
        next_cycle();
        mem_read_data = 32'hBAD0BAD0;
        @(negedge clock);
        check_bit("lat3 c4 data_valid", s3_data_valid, 1'b1);
        check_word("lat3 c4 data_read_data", s3_data_read_data, 32'hC0FFEE03);
        check_bit("lat3 c4 data_ready", s3_data_ready, 1'b1);
        check_bit("lat3 c4 mem_enable", s3_mem_enable, 1'b1);
        next_cycle();
        data_req = 1'b0;

        // Reset in the middle of a load
        apply_reset();
        data_req = 1'b1; data_address = 32'h64;
        @(negedge clock);
        check_bit("rst c0 data_ready", data_ready, 1'b1);
        next_cycle();
        data_req = 1'b0; reset = 1'b0; mem_read_data = 32'h99999999;
        @(negedge clock);
        check_bit("rst c1 data_valid", data_valid, 1'b0);
        next_cycle();
        reset = 1'b1;
        @(negedge clock);
        check_bit("rst c2 data_valid", data_valid, 1'b0);
        check_word("rst c2 data_read_data", data_read_data, 32'h0);
        check_word("rst c2 mem_address", mem_address, 32'h0);
        check_bit("rst c2 mem_enable", mem_enable, 1'b0);
        next_cycle();
        @(negedge clock);
        check_bit("rst c3 data_valid", data_valid, 1'b0);
        next_cycle();
        fetch_req = 1'b1; fetch_address = 32'h20;
        @(negedge clock);
        check_bit("rst new fetch_ready", fetch_ready, 1'b1);
        check_word("rst new mem_address", mem_address, 32'h20);
        next_cycle();
        fetch_req = 1'b0; mem_read_data = 32'h12345678;
        next_cycle();
        mem_read_data = 32'h0;
        @(negedge clock);
        check_bit("rst new fetch_valid", fetch_valid, 1'b1);
        check_word("rst new fetch_data", fetch_data, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
